// File: rtl/booth_divider.sv
// Sequential signed divider: 2*DW-bit dividend by DW-bit divisor, restoring
// iteration on magnitudes with a sign fix-up, truncating toward zero.
//
// state | meaning
// IDLE  | waiting for start; results and flags hold their last values
// ITER  | one restoring quotient bit per cycle, DW cycles
// FIX   | sign fix-up and range check, pulse done, return to IDLE
module booth_divider #(
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2*DW-1:0] x,
   input  logic [DW-1:0]   y,
   input  logic            start,
   output logic [DW-1:0]   q,
   output logic [DW-1:0]   r,
   output logic            ovf,
   output logic            dz,
   output logic            busy,
   output logic            done
);

   localparam int CW = $clog2(DW);
   localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);
   localparam logic [DW-1:0] MIN_MAG = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            sx_q, sx_d;
   logic            sy_q, sy_d;
   logic [DW-1:0]   ay_q, ay_d;
   logic [DW:0]     r_q, r_d;
   logic [DW-1:0]   d_q, d_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   quo_q, quo_d;
   logic [DW-1:0]   rem_q, rem_d;
   logic            ovf_q, ovf_d;
   logic            dz_q, dz_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [2*DW-1:0] ax_in;
   logic [DW-1:0]   ay_in;
   logic [DW:0]     t_cur;
   logic [DW:0]     t_sub;
   logic            t_ge;
   logic            neg_q;
   logic            range_ovf;

   assign ax_in = x[2*DW-1] ? -x : x;
   assign ay_in = y[DW-1] ? -y : y;

   assign t_cur = {r_q[DW-1:0], d_q[DW-1]};
   assign t_ge  = (t_cur >= {1'b0, ay_q});
   assign t_sub = t_cur - {1'b0, ay_q};

   // A negative result may reach magnitude 2^(DW-1); a positive one may not.
   assign neg_q     = sx_q ^ sy_q;
   assign range_ovf = neg_q ? (d_q > MIN_MAG) : d_q[DW-1];

   always_comb begin
      state_d = state_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      ay_d    = ay_q;
      r_d     = r_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               sx_d   = x[2*DW-1];
               sy_d   = y[DW-1];
               ay_d   = ay_in;
               r_d    = {1'b0, ax_in[2*DW-1:DW]};
               d_d    = ax_in[DW-1:0];
               cnt_d  = '0;
               quo_d  = '0;
               rem_d  = '0;
               ovf_d  = 1'b0;
               dz_d   = 1'b0;
               busy_d = 1'b1;
               if (y == '0) begin
                  dz_d    = 1'b1;
                  state_d = FIX;
               end else if (ax_in[2*DW-1:DW] >= ay_in) begin
                  ovf_d   = 1'b1;
                  state_d = FIX;
               end else begin
                  state_d = ITER;
               end
            end
         end

         ITER: begin
            r_d   = t_ge ? t_sub : t_cur;
            d_d   = {d_q[DW-2:0], t_ge};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = FIX;
            end
         end

         FIX: begin
            if (!(dz_q || ovf_q)) begin
               if (range_ovf) begin
                  ovf_d = 1'b1;
               end else begin
                  quo_d = neg_q ? -d_q : d_q;
                  rem_d = sx_q ? -r_q[DW-1:0] : r_q[DW-1:0];
               end
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         ay_q    <= '0;
         r_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         ay_q    <= ay_d;
         r_q     <= r_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign q    = quo_q;
   assign r    = rem_q;
   assign ovf  = ovf_q;
   assign dz   = dz_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_booth_divider.sv
// Directed bench for booth_divider: hand-computed vectors, handshake timing,
// ignored starts, mid-operation reset, plus a truncating-division reference.
module tb_booth_divider;

   localparam int DW = 16;

   logic            clk;
   logic            rst;
   logic [2*DW-1:0] x;
   logic [DW-1:0]   y;
   logic            start;
   logic [DW-1:0]   q;
   logic [DW-1:0]   r;
   logic            ovf;
   logic            dz;
   logic            busy;
   logic            done;

   int tests_run = 0;
   int tests_failed = 0;

   booth_divider #(.DW(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .x     (x),
      .y     (y),
      .start (start),
      .q     (q),
      .r     (r),
      .ovf   (ovf),
      .dz    (dz),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      assert (got === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Issue one operation; lat = edges after the start edge until done is seen,
   // bcnt = number of post-edge samples with busy high.
   task automatic run_op(input logic [2*DW-1:0] xv, input logic [DW-1:0] yv,
                         output int lat, output int bcnt);
      @(negedge clk);
      x     = xv;
      y     = yv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      bcnt  = busy ? 1 : 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy) bcnt++;
      end
   endtask

   task automatic vec(input string tag, input logic [2*DW-1:0] xv, input logic [DW-1:0] yv,
                      input logic [DW-1:0] eq, input logic [DW-1:0] er,
                      input logic eovf, input logic edz, input int elat);
      int lat, bcnt;
      run_op(xv, yv, lat, bcnt);
      check({tag, ".lat"}, 64'(lat), 64'(elat));
      check({tag, ".q"}, 64'(q), 64'(eq));
      check({tag, ".r"}, 64'(r), 64'(er));
      check({tag, ".ovf"}, 64'(ovf), 64'(eovf));
      check({tag, ".dz"}, 64'(dz), 64'(edz));
      check({tag, ".busy"}, 64'(bcnt), 64'(elat));
   endtask

   // Reference: exact truncating division in 64-bit signed arithmetic.
   task automatic rand_vec(input logic [2*DW-1:0] xv, input logic [DW-1:0] yv);
      longint xs, ys, qe, re;
      logic eovf, edz;
      logic [DW-1:0] eq, er;
      int lat, bcnt;
      xs   = longint'($signed(xv));
      ys   = longint'($signed(yv));
      edz  = (ys == 0);
      eovf = 1'b0;
      eq   = '0;
      er   = '0;
      if (!edz) begin
         qe = xs / ys;
         re = xs % ys;
         if (qe > 32767 || qe < -32768) eovf = 1'b1;
         else begin
            eq = qe[DW-1:0];
            er = re[DW-1:0];
         end
      end
      run_op(xv, yv, lat, bcnt);
      check("rnd.q", 64'(q), 64'(eq));
      check("rnd.r", 64'(r), 64'(er));
      check("rnd.ovf", 64'(ovf), 64'(eovf));
      check("rnd.dz", 64'(dz), 64'(edz));
      check("rnd.timeout", 64'(lat < 40), 64'(1));
   endtask

   initial begin
      int lat, bcnt, done_seen;
      logic [15:0] a16, b16;
      longint prod;

      rst   = 1'b1;
      start = 1'b0;
      x     = '0;
      y     = '0;
      repeat (3) @(negedge clk);
      check("rst.q", 64'(q), 64'(0));
      check("rst.r", 64'(r), 64'(0));
      check("rst.flags", 64'({ovf, dz, busy, done}), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      vec("pp", 32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17);
      @(negedge clk);
      check("pp.done_pulse", 64'(done), 64'(0));
      vec("np", 32'hFFFF_FF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17);
      vec("pn", 32'd100, 16'hFFF9, 16'hFFF2, 16'd2, 1'b0, 1'b0, 17);
      vec("nn", 32'hFFFF_FF9C, 16'hFFF9, 16'd14, 16'hFFFE, 1'b0, 1'b0, 17);
      vec("minq", 32'hFFFF_8000, 16'd1, 16'h8000, 16'd0, 1'b0, 1'b0, 17);
      vec("lateovf", 32'hC000_0000, 16'h8000, 16'd0, 16'd0, 1'b1, 1'b0, 17);
      vec("earlyovf", 32'h0001_0000, 16'd1, 16'd0, 16'd0, 1'b1, 1'b0, 1);
      vec("divzero", 32'd5, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1);
      vec("prod", 32'hFFF5_52E2, 16'd567, 16'hFB2E, 16'd0, 1'b0, 1'b0, 17);
      vec("maxsq", 32'h3FFF_0001, 16'h7FFF, 16'h7FFF, 16'd0, 1'b0, 1'b0, 17);

      // Starts during busy (cycle 3 and the FIX cycle) must be ignored.
      @(negedge clk);
      x     = 32'd100;
      y     = 16'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (lat == 3 || lat == 16) begin
            x     = 32'd5;
            y     = 16'd0;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check("ign.lat", 64'(lat), 64'(17));
      check("ign.q", 64'(q), 64'(14));
      check("ign.r", 64'(r), 64'(2));
      check("ign.dz", 64'(dz), 64'(0));
      @(negedge clk);
      check("ign.idle", 64'(busy), 64'(0));

      // Reset in the middle of an operation aborts it with no done.
      @(negedge clk);
      x     = 32'd100;
      y     = 16'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort.q", 64'(q), 64'(0));
      check("abort.r", 64'(r), 64'(0));
      check("abort.flags", 64'({ovf, dz, busy, done}), 64'(0));
      rst = 1'b0;
      done_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("abort.nodone", 64'(done_seen), 64'(0));
      vec("after", 32'hFFFF_FF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17);

      // Exact products must divide back with zero remainder.
      for (int i = 0; i < 200; i++) begin
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         if (b16 == 16'd0) b16 = 16'd1;
         prod = longint'($signed(a16)) * longint'($signed(b16));
         rand_vec(prod[31:0], b16);
      end
      for (int i = 0; i < 200; i++) begin
         rand_vec(32'($urandom) >> $urandom_range(0, 24), 16'($urandom) >> $urandom_range(0, 15));
      end
      rand_vec(32'h8000_0000, 16'hFFFF);
      rand_vec(32'h8000_0000, 16'h8000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
